// File: rtl/main_fsm.sv
// main_fsm -- multicycle RV32 control unit (Moore machine).
//
// Sequences each instruction through FETCH / DECODE and an opcode-specific
// tail of states, driving datapath strobes and mux selects. Every output is a
// function of the current state only; they are held in flops next to the state
// register, so they change on the same edge as the state.
//
// Ports:
//   clk        in   1  single clock, rising edge
//   reset      in   1  asynchronous, active-high reset (forces FETCH)
//   op         in   7  opcode from the instruction register
//   Branch     out  1  branch-qualify strobe (PC loads on Branch & Zero)
//   PCUpdate   out  1  unconditional PC write enable
//   RegWrite   out  1  register file write enable
//   MemWrite   out  1  data memory write enable
//   IRWrite    out  1  instruction register / old-PC write enable
//   ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA    out  2  00 PC, 01 OldPC, 10 rs1
//   ALUSrcB    out  2  00 rs2, 01 ImmExt, 10 constant 4
//   AdrSrc     out  1  0 PC, 1 Result
//   ALUOp      out  2  00 add, 01 subtract, 10 decode funct3/funct7
//   illegal    out  1  sticky undefined-opcode flag
//   state      out  4  current state encoding (debug)
//
// Configuration:
//   MAIN_FSM_ILLEGAL_TRAP_EN  when defined, an undefined opcode parks the
//                             machine in TRAP (illegal=1) until reset. When
//                             undefined, it returns to FETCH and illegal is 0.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  output logic       Branch,
  output logic       PCUpdate,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       AdrSrc,
  output logic [1:0] ALUOp,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  typedef struct packed {
    logic       branch;
    logic       pc_update;
    logic       reg_write;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       adr_src;
    logic [1:0] alu_op;
  } ctl_t;

  // Transition rules. op is only consulted in DECODE and MEMADR; it is held
  // stable by the datapath for the whole instruction.
  function automatic state_t next_for(input state_t s, input logic [6:0] o);
    case (s)
      S_FETCH:  return S_DECODE;
      S_DECODE: begin
        case (o)
          7'b0000011, 7'b0100011: return S_MEMADR;
          7'b0110011:             return S_EXECR;
          7'b0010011:             return S_EXECI;
          7'b1100011:             return S_BEQ;
          7'b1101111:             return S_JAL;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
          default:                return S_TRAP;
`else
          default:                return S_FETCH;
`endif
        endcase
      end
      // op[5] separates sw (0100011) from lw (0000011).
      S_MEMADR:   return o[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  return S_MEMWB;
      S_MEMWB:    return S_FETCH;
      S_MEMWRITE: return S_FETCH;
      S_EXECR:    return S_ALUWB;
      S_EXECI:    return S_ALUWB;
      S_ALUWB:    return S_FETCH;
      S_BEQ:      return S_FETCH;
      S_JAL:      return S_ALUWB;
      S_TRAP:     return S_TRAP;
      default:    return S_FETCH;
    endcase
  endfunction

  // Moore output table; anything not set stays 0 (TRAP is all zeros).
  function automatic ctl_t outs_for(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.pc_update  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t st_q;
  state_t st_nxt;
  ctl_t   ctl_q;

  always_comb begin
    st_nxt = next_for(st_q, op);
  end

  // NOTE: reset is in the sensitivity list, so it takes effect immediately,
  // not at the next clock; outputs are reloaded with the FETCH values too so
  // they never disagree with the state while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q  <= S_FETCH;
      ctl_q <= outs_for(S_FETCH);
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      st_q  <= st_nxt;
      ctl_q <= outs_for(st_nxt);
    end
  end

`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky by construction: TRAP only exits through reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= (st_nxt == S_TRAP);
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign Branch    = ctl_q.branch;
  assign PCUpdate  = ctl_q.pc_update;
  assign RegWrite  = ctl_q.reg_write;
  assign MemWrite  = ctl_q.mem_write;
  assign IRWrite   = ctl_q.ir_write;
  assign ResultSrc = ctl_q.result_src;
  assign ALUSrcA   = ctl_q.alu_src_a;
  assign ALUSrcB   = ctl_q.alu_src_b;
  assign AdrSrc    = ctl_q.adr_src;
  assign ALUOp     = ctl_q.alu_op;
  assign state     = st_q;

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm -- self-checking bench for main_fsm.
//
// A reference model gives, per opcode, the list of states the instruction
// walks through and, per state, the control word the datapath should see.
// Directed opcodes come first, then randomly chosen legal and undefined
// opcodes, plus an asynchronous reset landing in the middle of a load.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       Branch, PCUpdate, RegWrite, MemWrite, IRWrite, AdrSrc, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state;

  always #5 clk = ~clk;

  main_fsm dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .Branch   (Branch),
    .PCUpdate (PCUpdate),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .ResultSrc(ResultSrc),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .AdrSrc   (AdrSrc),
    .ALUOp    (ALUOp),
    .illegal  (illegal),
    .state    (state)
  );

  // Observed control word: {Branch,PCUpdate,RegWrite,MemWrite,IRWrite,
  //                         ResultSrc,ALUSrcA,ALUSrcB,AdrSrc,ALUOp}
  logic [13:0] obs_ctl;
  assign obs_ctl = {Branch, PCUpdate, RegWrite, MemWrite, IRWrite,
                    ResultSrc, ALUSrcA, ALUSrcB, AdrSrc, ALUOp};

  logic [13:0] exp_ctl [12];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          exp_q [$];
  logic [6:0]  legal_ops [6];

  function automatic logic [13:0] mk(input logic br, input logic pcu,
                                     input logic rw, input logic mw,
                                     input logic irw, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic adr, input logic [1:0] aop);
    return {br, pcu, rw, mw, irw, rs, a, b, adr, aop};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected state walk of one instruction, starting in FETCH.
  task automatic build_seq(input logic [6:0] o);
    case (o)
      7'b0000011: exp_q = {0, 1, 2, 3, 4};
      7'b0100011: exp_q = {0, 1, 2, 5};
      7'b0110011: exp_q = {0, 1, 6, 8};
      7'b0010011: exp_q = {0, 1, 7, 8};
      7'b1100011: exp_q = {0, 1, 9};
      7'b1101111: exp_q = {0, 1, 10, 8};
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      default:    exp_q = {0, 1, 11};
`else
      default:    exp_q = {0, 1};
`endif
    endcase
  endtask

  task automatic check_state(input string tag, input int s);
    check({tag, "_state"}, 32'(state), 32'(s));
    check({tag, "_ctl"}, 32'(obs_ctl), 32'(exp_ctl[s]));
    check({tag, "_illegal"}, 32'(illegal), 32'(s == 11));
  endtask

  // Called at a falling edge; leaves the machine in FETCH with reset released
  // at a falling edge, so the next rising edge moves to DECODE.
  task automatic do_reset;
    #2 reset = 1'b1;
    #1 check_state("rst_async", 0);
    @(negedge clk);
    check_state("rst_held", 0);
    reset = 1'b0;
  endtask

  // Called at a falling edge while in FETCH.
  task automatic run_instr(input logic [6:0] o);
    string tag;
    tag = $sformatf("op%07b", o);
    op  = o;
    build_seq(o);
    foreach (exp_q[i]) begin
      check_state($sformatf("%s_c%0d", tag, i), exp_q[i]);
      @(negedge clk);
    end
    if (exp_q[exp_q.size()-1] == 11) begin
      for (int k = 0; k < 3; k++) begin
        check_state($sformatf("%s_trap_hold%0d", tag, k), 11);
        @(negedge clk);
      end
      do_reset();
    end else begin
      check($sformatf("%s_back_to_fetch", tag), 32'(state), 32'd0);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] o);
    foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic [6:0] o;

    exp_ctl[0]  = mk(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 2'b00);
    exp_ctl[1]  = mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00);
    exp_ctl[2]  = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00);
    exp_ctl[3]  = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00);
    exp_ctl[4]  = mk(0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 0, 2'b00);
    exp_ctl[5]  = mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00);
    exp_ctl[6]  = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b10);
    exp_ctl[7]  = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b10);
    exp_ctl[8]  = mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00);
    exp_ctl[9]  = mk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b01);
    exp_ctl[10] = mk(0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 2'b00);
    exp_ctl[11] = '0;

    legal_ops[0] = 7'b0000011;
    legal_ops[1] = 7'b0100011;
    legal_ops[2] = 7'b0110011;
    legal_ops[3] = 7'b0010011;
    legal_ops[4] = 7'b1100011;
    legal_ops[5] = 7'b1101111;

    // Reset from power-up: FETCH outputs before and across clock edges.
    reset = 1'b1;
    op    = 7'(legal_ops[2]);
    #1 check_state("por", 0);
    @(negedge clk);
    check_state("por_edge", 0);
    reset = 1'b0;

    // Directed: every opcode class once, then an undefined opcode.
    foreach (legal_ops[i]) run_instr(legal_ops[i]);
    run_instr(7'b1111111);

    // Asynchronous reset landing in MEMREAD of a load.
    op = 7'b0000011;
    check_state("mid_c0", 0);
    @(negedge clk); check_state("mid_c1", 1);
    @(negedge clk); check_state("mid_c2", 2);
    @(negedge clk); check_state("mid_c3", 3);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_irwrite", 32'(IRWrite), 32'd1);
    check("mid_rst_pcupdate", 32'(PCUpdate), 32'd1);
    check("mid_rst_ctl", 32'(obs_ctl), 32'(exp_ctl[0]));
    #1 reset = 1'b0;
    @(negedge clk);
    check_state("mid_after_rst", 1);
    @(negedge clk); check_state("mid_resume2", 2);
    @(negedge clk); check_state("mid_resume3", 3);
    @(negedge clk); check_state("mid_resume4", 4);
    @(negedge clk);
    check("mid_back_to_fetch", 32'(state), 32'd0);

    // Randomized instruction stream, mostly legal with some undefined opcodes.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        do o = 7'($urandom_range(0, 127)); while (is_legal(o));
      end else begin
        o = legal_ops[$urandom_range(0, 5)];
      end
      run_instr(o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 Parameters: none; the module SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  7  opcode field from the instruction register; held stable from Decode until the return to Fetch.
REQ-005 Branch  output  1  branch-qualify strobe; PC loads when Branch & Zero.
REQ-006 PCUpdate  output  1  unconditional PC write enable.
REQ-007 RegWrite  output  1  register file write enable.
REQ-008 MemWrite  output  1  data memory write enable.
REQ-009 IRWrite  output  1  instruction register and old-PC write enable.
REQ-010 ResultSrc  output  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult.
REQ-011 ALUSrcA  output  2  ALU A mux: 00 PC, 01 OldPC, 10 rs1 data.
REQ-012 ALUSrcB  output  2  ALU B mux: 00 rs2 data, 01 ImmExt, 10 constant 4.
REQ-013 AdrSrc  output  1  memory address mux: 0 PC, 1 Result.
REQ-014 ALUOp  output  2  to the ALU decoder: 00 add, 01 subtract, 10 decode funct3/funct7.
REQ-015 illegal  output  1  sticky undefined-opcode flag.
REQ-016 state  output  4  current state encoding, for debug and verification.

Function
REQ-017 Moore machine: all outputs SHALL be decoded from the current state only; any output not listed for a state SHALL be 0.
REQ-018 State encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 11.
REQ-019 FETCH SHALL drive AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1, and go to DECODE.
REQ-020 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00.
REQ-021 DECODE SHALL branch on op: 0000011 or 0100011 to MEMADR, 0110011 to EXECR, 0010011 to EXECI, 1100011 to BEQ, 1101111 to JAL; any other value is handled per REQ-031/032.
REQ-022 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, and go to MEMWRITE if op[5]=1, else to MEMREAD.
REQ-023 MEMREAD SHALL drive ResultSrc=00, AdrSrc=1, and go to MEMWB.
REQ-024 MEMWB SHALL drive ResultSrc=01, RegWrite=1, and go to FETCH.
REQ-025 MEMWRITE SHALL drive ResultSrc=00, AdrSrc=1, MemWrite=1, and go to FETCH.
REQ-026 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=10. Both SHALL go to ALUWB.
REQ-027 ALUWB SHALL drive ResultSrc=00, RegWrite=1, and go to FETCH.
REQ-028 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, and go to FETCH.
REQ-029 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, and go to ALUWB.
REQ-030 Instruction latency SHALL be: lw 5 cycles; sw, R-type, I-type ALU and jal 4 cycles; beq 3 cycles. Counts include FETCH.

Configuration
REQ-031 With macro MAIN_FSM_ILLEGAL_TRAP_EN defined, an undefined op in DECODE SHALL go to TRAP.
- In TRAP, all strobes and mux selects SHALL be 0 and illegal=1.
- TRAP SHALL self-loop until reset.
REQ-032 Without MAIN_FSM_ILLEGAL_TRAP_EN, an undefined op in DECODE SHALL go to FETCH, TRAP SHALL be unreachable, and illegal SHALL be tied to 0.

Reset
REQ-033 Asserting reset SHALL force the state to FETCH immediately, without waiting for a clock edge, from any state including mid-instruction and TRAP.
REQ-034 While reset is high, outputs SHALL therefore equal the FETCH values (IRWrite=1, PCUpdate=1, all others per REQ-019) and illegal=0.
REQ-035 On the first rising clk edge after reset deasserts, the state SHALL go to DECODE.

Verification
REQ-036 op=0000011 after reset: state sequence 0,1,2,3,4,0. RegWrite=1 only in state 4; ResultSrc=01 there.
REQ-037 op=0100011: sequence 0,1,2,5,0. MemWrite=1 for exactly one cycle, with AdrSrc=1.
REQ-038 op=0110011, then op=0010011: both give 0,1,6 or 7,8,0. ALUOp=10 in states 6 and 7. ALUSrcB is 00 in state 6 and 01 in state 7.
REQ-039 op=1100011: sequence 0,1,9,0 with Branch=1 and ALUOp=01 in state 9. op=1101111: sequence 0,1,10,8,0 with PCUpdate=1 in state 10.
REQ-040 op=1111111: with the macro, sequence 0,1,11,11,... with illegal=1, held until reset. Without the macro, sequence 0,1,0 with illegal=0.
REQ-041 Assert reset asynchronously while in MEMREAD: state=0 before the next clk edge, IRWrite=1 and PCUpdate=1. After reset deasserts, the next edge gives state=1.
